// File: rtl/t05_pkg.sv
// Shared header-format definitions for the Huffman header encoder and decoder.
package t05_pkg;

  localparam int HDR_PATH_W = 128;
  localparam int HDR_TOT_W  = 32;

  typedef enum logic [3:0] {
    IDLE,
    SEND_PATH,
    WAIT_LEAF,
    SEND_LEAD,
    SEND_CHAR,
    SEND_ZEROS,
    SEND_TOT,
    PAD,
    FLUSH,
    DONE
  } state_he;

endpackage

// File: rtl/t05_bit_packer.sv
// Collects one header bit per cycle into bytes (first bit lands in the MSB) and
// owns the valid/ready handshake toward the SPI writer.
module t05_bit_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_stall,
  output logic [3:0] bit_cnt,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready
);

  logic [6:0] sr;

  assign bit_stall = (bit_cnt == 4'd8);

  // The eighth bit raises byte_valid directly, so a byte with an always-ready
  // sink costs 8 shift cycles plus one accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= '0;
      bit_cnt    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else if (byte_valid) begin
      if (byte_ready) begin
        byte_valid <= 1'b0;
        bit_cnt    <= '0;
      end
    end else if (bit_valid) begin
      sr      <= {sr[5:0], bit_in};
      bit_cnt <= bit_cnt + 4'd1;
      if (bit_cnt == 4'd7) begin
        byte_valid <= 1'b1;
        byte_data  <= {sr, bit_in};
      end
    end
  end

endmodule

// File: rtl/t05_hd_encode.sv
// Header encoder: serializes first-leaf path, DFS leaf tokens and the character
// total into the byte stream consumed by the header decoder.
module t05_hd_encode
  import t05_pkg::*;
#(
  parameter int PATH_W = HDR_PATH_W,
  parameter int BT_W   = 8,
  parameter int TOT_W  = HDR_TOT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              he_enable,
  input  logic [PATH_W-1:0] path_in,
  input  logic              leaf_valid,
  output logic              leaf_ready,
  input  logic [7:0]        leaf_char,
  input  logic [BT_W-1:0]   leaf_bt,
  input  logic              leaf_last,
  input  logic [TOT_W-1:0]  tot_chars,
  output logic [7:0]        SPI_data_out,
  output logic              write_en_SPI,
  input  logic              SPI_ready,
  output logic              finished
);

  localparam int PB_W = $clog2(PATH_W);
  localparam int TB_W = $clog2(TOT_W);
  localparam int BC_W = (PB_W > TB_W) ? PB_W : TB_W;

  state_he           state;
  logic [BC_W-1:0]   bitcnt;
  logic [PATH_W-1:0] path_r;
  logic [7:0]        char_r;
  logic [BT_W-1:0]   bt_r;
  logic              last_r;
  logic [TOT_W-1:0]  tot_r;

  logic       hdr_bit;
  logic       emit;
  logic       bit_valid;
  logic       bit_stall;
  logic [3:0] pk_cnt;

  assign leaf_ready = (state == WAIT_LEAF);
  assign finished   = (state == DONE);
  assign bit_valid  = emit && !bit_stall;

  always_comb begin
    hdr_bit = 1'b0;
    emit    = 1'b0;
    unique case (state)
      SEND_PATH: begin
        emit    = 1'b1;
        hdr_bit = path_r[bitcnt[PB_W-1:0]];
      end
      SEND_LEAD: begin
        emit    = 1'b1;
        hdr_bit = 1'b1;
      end
      SEND_CHAR: begin
        emit    = 1'b1;
        hdr_bit = char_r[bitcnt[2:0]];
      end
      SEND_ZEROS: emit = 1'b1;
      SEND_TOT: begin
        emit    = 1'b1;
        hdr_bit = tot_r[bitcnt[TB_W-1:0]];
      end
      // Pad only a partial byte; an aligned header gets no extra byte.
      PAD:     emit = (pk_cnt != 4'd0);
      default: emit = 1'b0;
    endcase
  end

  // Every emitting state advances only on a cycle where the packer took the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= '0;
      path_r <= '0;
      char_r <= '0;
      bt_r   <= '0;
      last_r <= 1'b0;
      tot_r  <= '0;
    end else begin
      unique case (state)
        IDLE: if (he_enable) begin
          path_r <= path_in;
          bitcnt <= BC_W'(PATH_W - 1);
          state  <= SEND_PATH;
        end
        SEND_PATH: if (bit_valid) begin
          if (bitcnt == '0) state <= WAIT_LEAF;
          else              bitcnt <= bitcnt - BC_W'(1);
        end
        WAIT_LEAF: if (leaf_valid) begin
          char_r <= leaf_char;
          bt_r   <= leaf_bt;
          last_r <= leaf_last;
          if (leaf_last) tot_r <= tot_chars;
          state  <= SEND_LEAD;
        end
        SEND_LEAD: if (bit_valid) begin
          bitcnt <= BC_W'(7);
          state  <= SEND_CHAR;
        end
        SEND_CHAR: if (bit_valid) begin
          if (bitcnt == '0) begin
            bitcnt <= BC_W'(TOT_W - 1);
            if (bt_r != '0) state <= SEND_ZEROS;
            else            state <= last_r ? SEND_TOT : WAIT_LEAF;
          end else begin
            bitcnt <= bitcnt - BC_W'(1);
          end
        end
        SEND_ZEROS: if (bit_valid) begin
          bt_r <= bt_r - BT_W'(1);
          if (bt_r == BT_W'(1)) state <= last_r ? SEND_TOT : WAIT_LEAF;
        end
        SEND_TOT: if (bit_valid) begin
          if (bitcnt == '0) state <= PAD;
          else              bitcnt <= bitcnt - BC_W'(1);
        end
        PAD:     if (pk_cnt == 4'd0 || bit_stall) state <= FLUSH;
        FLUSH:   if (pk_cnt == 4'd0 && !write_en_SPI) state <= DONE;
        DONE:    if (!he_enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  t05_bit_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (hdr_bit),
    .bit_valid (bit_valid),
    .bit_stall (bit_stall),
    .bit_cnt   (pk_cnt),
    .byte_data (SPI_data_out),
    .byte_valid(write_en_SPI),
    .byte_ready(SPI_ready)
  );

endmodule

// File: tb/tb_t05_hd_encode.sv
// Scoreboard bench for the header encoder: expected bytes are queued per run and
// popped by a monitor on every accepted SPI byte.
module tb_t05_hd_encode;

  typedef struct {
    logic [7:0] ch;
    logic [7:0] bt;
  } leaf_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         he_enable = 1'b0;
  logic [127:0] path_in = '0;
  logic         leaf_valid = 1'b0;
  logic         leaf_ready;
  logic [7:0]   leaf_char = '0;
  logic [7:0]   leaf_bt = '0;
  logic         leaf_last = 1'b0;
  logic [31:0]  tot_chars = '0;
  logic [7:0]   SPI_data_out;
  logic         write_en_SPI;
  logic         SPI_ready = 1'b1;
  logic         finished;

  int         n_checks = 0;
  int         n_fail = 0;
  int         byte_idx = 0;
  int         exp_n = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  leaf_t      leaves[$];
  logic       bp_en = 1'b0;
  int         stall_cnt = 0;
  int         last_stalled = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always #5 clk = ~clk;

  t05_hd_encode dut (
    .clk         (clk),
    .rst         (rst),
    .he_enable   (he_enable),
    .path_in     (path_in),
    .leaf_valid  (leaf_valid),
    .leaf_ready  (leaf_ready),
    .leaf_char   (leaf_char),
    .leaf_bt     (leaf_bt),
    .leaf_last   (leaf_last),
    .tot_chars   (tot_chars),
    .SPI_data_out(SPI_data_out),
    .write_en_SPI(write_en_SPI),
    .SPI_ready   (SPI_ready),
    .finished    (finished)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks hold-stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_write_en", longint'(write_en_SPI), 1);
        check("hold_data", longint'(SPI_data_out), longint'(prev_data));
      end
      if (write_en_SPI && SPI_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_byte: got 0x%0h, expected no byte", SPI_data_out);
        end else begin
          check($sformatf("byte%0d", byte_idx + 1), longint'(SPI_data_out),
                longint'(exp_q.pop_front()));
        end
        got_q.push_back(SPI_data_out);
        byte_idx++;
      end
      prev_stall = write_en_SPI && !SPI_ready;
      prev_data  = SPI_data_out;
    end
  end

  // Backpressure: hold SPI_ready low 5 cycles when bytes 1, 16 and 33 are offered.
  always begin
    @(posedge clk);
    #1;
    if (bp_en && write_en_SPI && stall_cnt == 0 && last_stalled != byte_idx + 1 &&
        (byte_idx + 1 == 1 || byte_idx + 1 == 16 || byte_idx + 1 == 33)) begin
      stall_cnt    = 5;
      last_stalled = byte_idx + 1;
    end
    if (stall_cnt > 0) begin
      SPI_ready = 1'b0;
      stall_cnt--;
    end else begin
      SPI_ready = 1'b1;
    end
  end

  task automatic load_case1();
    leaves.delete();
    leaves.push_back('{8'd67, 8'd0});
    leaves.push_back('{8'd66, 8'd1});
    leaves.push_back('{8'd65, 8'd1});
    leaves.push_back('{8'd70, 8'd0});
    leaves.push_back('{8'd71, 8'd2});
    leaves.push_back('{8'd74, 8'd0});
    leaves.push_back('{8'd68, 8'd0});
    leaves.push_back('{8'd69, 8'd1});
    leaves.push_back('{8'd72, 8'd0});
    leaves.push_back('{8'd73, 8'd4});
  endtask

  task automatic build_expected(input logic [127:0] path, input logic [31:0] tot);
    bit         bits[$];
    logic [7:0] b;
    exp_q.delete();
    for (int i = 127; i >= 0; i--) bits.push_back(path[i]);
    foreach (leaves[k]) begin
      bits.push_back(1'b1);
      for (int i = 7; i >= 0; i--) bits.push_back(leaves[k].ch[i]);
      for (int j = 0; j < int'(leaves[k].bt); j++) bits.push_back(1'b0);
    end
    for (int i = 31; i >= 0; i--) bits.push_back(tot[i]);
    while (bits.size() % 8 != 0) bits.push_back(1'b0);
    for (int i = 0; i < bits.size(); i += 8) begin
      b = '0;
      for (int j = 0; j < 8; j++) b = {b[6:0], bits[i + j]};
      exp_q.push_back(b);
    end
    exp_n = exp_q.size();
  endtask

  task automatic run_case(input logic [127:0] path, input logic [31:0] tot,
                          input int abort_at, input int starve_at, input bit hold_en);
    int t;
    bit ok;
    build_expected(path, tot);
    byte_idx = 0;
    got_q.delete();
    path_in   = path;
    he_enable = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_en) he_enable = 1'b0;
    for (int i = 0; i < leaves.size(); i++) begin
      if (i == starve_at) begin
        t = 0;
        while (!leaf_ready) begin
          @(negedge clk);
          if (++t > 2000) begin
            fail_now("starve_wait");
            return;
          end
        end
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          check("starve_write_en", longint'(write_en_SPI), 0);
          check("starve_leaf_ready", longint'(leaf_ready), 1);
        end
        @(posedge clk);
        #1;
      end
      leaf_valid = 1'b1;
      leaf_char  = leaves[i].ch;
      leaf_bt    = leaves[i].bt;
      leaf_last  = (i == leaves.size() - 1);
      tot_chars  = leaf_last ? tot : 32'hDEAD_BEEF;
      t  = 0;
      ok = 1'b0;
      while (!ok) begin
        @(negedge clk);
        if (abort_at > 0 && byte_idx >= abort_at) begin
          leaf_valid = 1'b0;
          return;
        end
        if (leaf_ready) ok = 1'b1;
        else if (++t > 3000) begin
          fail_now("leaf_handshake");
          leaf_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
      leaf_valid = 1'b0;
      leaf_last  = 1'b0;
      tot_chars  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("leaf_consumed", longint'(leaf_ready), 0);
    end
    t = 0;
    while (!finished) begin
      @(negedge clk);
      if (abort_at > 0 && byte_idx >= abort_at) return;
      if (++t > 5000) begin
        fail_now("finished_wait");
        return;
      end
    end
    check("byte_count", longint'(got_q.size()), longint'(exp_n));
    check("queue_drained", longint'(exp_q.size()), 0);
    check("finished", longint'(finished), 1);
  endtask

  task automatic check_case1_bytes();
    check("c1_len", longint'(got_q.size()), 33);
    if (got_q.size() == 33) begin
      for (int i = 0; i < 15; i++) check("c1_path_zero", longint'(got_q[i]), 0);
      check("c1_byte16", longint'(got_q[15]), 'h10);
      check("c1_byte17", longint'(got_q[16]), 'hA1);
      check("c1_byte33", longint'(got_q[32]), 'h40);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_cycles(3);
    @(negedge clk);
    check("rst_write_en", longint'(write_en_SPI), 0);
    check("rst_data", longint'(SPI_data_out), 0);
    check("rst_finished", longint'(finished), 0);
    check("rst_leaf_ready", longint'(leaf_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);

    // Ten-leaf tree, always-ready sink, one-cycle enable pulse.
    load_case1();
    run_case(128'b10000, 32'd10, 0, -1, 1'b0);
    check_case1_bytes();
    idle_cycles(3);

    // Same tree with backpressure at bytes 1, 16 and 33.
    bp_en = 1'b1;
    last_stalled = 0;
    run_case(128'b10000, 32'd10, 0, -1, 1'b0);
    check_case1_bytes();
    bp_en = 1'b0;
    idle_cycles(3);

    // Header that ends exactly on a byte boundary.
    leaves.delete();
    leaves.push_back('{8'h41, 8'd7});
    run_case(128'd0, 32'd1, 0, -1, 1'b0);
    check("c3_len", longint'(got_q.size()), 22);
    if (got_q.size() == 22) begin
      check("c3_byte17", longint'(got_q[16]), 'hA0);
      check("c3_byte18", longint'(got_q[17]), 'h80);
      check("c3_byte22", longint'(got_q[21]), 'h01);
    end
    idle_cycles(3);

    // Leaf starvation after the first leaf.
    load_case1();
    run_case(128'b10000, 32'd10, 0, 1, 1'b0);
    check_case1_bytes();
    idle_cycles(3);

    // Reset after byte 20, then a clean rerun.
    run_case(128'b10000, 32'd10, 20, -1, 1'b0);
    check("abort_point", longint'(byte_idx >= 20), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    leaf_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_write_en", longint'(write_en_SPI), 0);
    check("midrst_data", longint'(SPI_data_out), 0);
    check("midrst_finished", longint'(finished), 0);
    check("midrst_leaf_ready", longint'(leaf_ready), 0);
    idle_cycles(12);
    check("midrst_no_bytes", longint'(exp_q.size()), 0);
    run_case(128'b10000, 32'd10, 0, -1, 1'b0);
    check_case1_bytes();
    idle_cycles(3);

    // Enable held high through DONE: no restart, finished stays up.
    leaves.delete();
    leaves.push_back('{8'h41, 8'd7});
    run_case(128'd0, 32'd1, 0, -1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_finished", longint'(finished), 1);
      check("hold_no_write", longint'(write_en_SPI), 0);
    end
    @(posedge clk);
    #1;
    he_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("finished_drop", longint'(finished), 0);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
